tx_serializer: RTL



---
 rtl/tx_serializer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tx_serializer.sv
// ---------------------------------------------------------------------------
// tx_serializer
//
// Serial transmitter at the output end of the memory read path. A TxData
// request in IDLE captures DataIn and sends one framed character on TxOut:
// start bit (0), DATA_WIDTH data bits LSB first, an optional even-parity bit,
// and a stop bit (1). Each bit lasts BIT_CYCLES clocks. A one-cycle TxDone
// pulse follows the edge that ends the stop bit.
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   TxData       in   transmit request, sampled only in IDLE
//   DataIn       in   character to send, captured on the accepting edge
//   TxOut        out  serial line, idles high (registered)
//   TxBusy       out  high from the accepting edge to the STOP->IDLE edge
//   TxDone       out  one-cycle pulse after the final stop cycle
//   dbg_state_o  out  current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: TxData is a level request examined only while the FSM is in
// IDLE; the edge that sees it high is the accepting edge. Requests in any
// other state are dropped, not queued. TxDone is the completion strobe and is
// never high together with TxBusy.
// ---------------------------------------------------------------------------
module tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  TxData,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  TxOut,
  output logic                  TxBusy,
  output logic                  TxDone,
  output logic [2:0]            dbg_state_o
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  // Last clock of the current serial bit.
  assign bit_end = (cyc_q == CYC_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // tx_d always carries the value of the bit that starts on this edge, so
  // TxOut can be a plain register with no output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cyc_d   = bit_end ? '0 : cyc_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cyc_d  = '0;
        if (TxData) begin
          shift_d = DataIn;
          par_d   = 1'b0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              // Parity must include the bit that is finishing right now.
              tx_d    = par_q ^ shift_q[0];
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign TxOut       = tx_q;
  assign TxBusy      = busy_q;
  assign TxDone      = done_q;
  assign dbg_state_o = state_q;

endmodule
